// File: rtl/grf_multiport.sv
// Parametrised multi-read-port register file: byte-enable writes, optional write bypass, sequenced bulk clear.
// Reads are zero-latency and writes land on the next edge; there is no backpressure, and writes are dropped while clearing.
module grf_multiport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W/8-1:0]        wr_be,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       clr_req,
    output logic                       clr_busy,
    output logic                       clr_done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   idx, idx_nxt;
    logic [DATA_W-1:0]   regs [DEPTH];
    logic                wr_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Clear walks idx from 1 to DEPTH-1; register 0 is never stored to, so it needs no clearing.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    idx_nxt   = ADDR_W'(1);
                end
            end
            CLEAR: begin
                idx_nxt = idx + ADDR_W'(1);
                if (idx == ADDR_W'(DEPTH - 1)) begin
                    state_nxt = DONE;
                    idx_nxt   = '0;
                end
            end
            DONE: state_nxt = IDLE;
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    assign clr_busy = (state == CLEAR);
    assign clr_done = (state == DONE);
    assign wr_ok    = wr_en && (wr_addr != '0) && (state != CLEAR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (state == CLEAR) begin
            regs[idx] <= '0;
        end else if (wr_ok) begin
            for (int b = 0; b < NB; b++)
                if (wr_be[b]) regs[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] v;

        assign a = rd_addr[k*ADDR_W +: ADDR_W];

        // Forwarded bytes overlay the stored word so partial writes read back merged.
        always_comb begin
            v = (a == '0) ? '0 : regs[a];
            if ((BYPASS != 0) && wr_ok && (a == wr_addr)) begin
                for (int b = 0; b < NB; b++)
                    if (wr_be[b]) v[8*b +: 8] = wr_data[8*b +: 8];
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = v;
    end

endmodule
